// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared control type, width helpers and configuration check for dsp_mac_pipe
package dsp_pkg;

  localparam int DEF_A_WIDTH = 36;
  localparam int DEF_B_WIDTH = 36;
  localparam int PROD_W      = DEF_A_WIDTH + DEF_B_WIDTH;

  typedef struct packed {
    logic is_signed;
    logic addsub;
    logic loadc;
    logic cin;
    logic valid;
  } ctrl_t;

  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic bit widths_ok(input int a_w, input int b_w, input int z_w,
                                   input int in_regs, input int pipe_regs);
    return (a_w > 0) && (b_w > 0) && (z_w >= a_w + b_w) &&
           (in_regs >= 0) && (in_regs <= 2) && (pipe_regs >= 0) && (pipe_regs <= 2);
  endfunction

endpackage

// File: rtl/dsp_mult_stage.sv
// rtl/dsp_mult_stage.sv - signed/unsigned multiplier with PIPE_REGS product stages and matched control/C delay
module dsp_mult_stage
  import dsp_pkg::*;
#(
  parameter int  A_WIDTH   = 36,
  parameter int  B_WIDTH   = 36,
  parameter int  Z_WIDTH   = 108,
  parameter int  PIPE_REGS = 1,
  localparam int PW        = prod_width(A_WIDTH, B_WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  ctrl_t              ctrl_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  input  logic [Z_WIDTH-1:0] c_i,
  output ctrl_t              ctrl_o,
  output logic [PW-1:0]      prod_o,
  output logic [Z_WIDTH-1:0] c_o
);

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  // Extending both operands to the full product width lets one modular multiply serve both modes
  assign a_ext = {{B_WIDTH{ctrl_i.is_signed & a_i[A_WIDTH-1]}}, a_i};
  assign b_ext = {{A_WIDTH{ctrl_i.is_signed & b_i[B_WIDTH-1]}}, b_i};
  assign prod  = a_ext * b_ext;

  if (PIPE_REGS == 0) begin : g_comb
    assign ctrl_o = ctrl_i;
    assign prod_o = prod;
    assign c_o    = c_i;
  end else begin : g_pipe
    ctrl_t              ctrl_q [PIPE_REGS];
    logic [PW-1:0]      prod_q [PIPE_REGS];
    logic [Z_WIDTH-1:0] c_q    [PIPE_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_REGS; i++) begin
          ctrl_q[i] <= '0;
          prod_q[i] <= '0;
          c_q[i]    <= '0;
        end
      end else if (ce) begin
        ctrl_q[0] <= ctrl_i;
        prod_q[0] <= prod;
        c_q[0]    <= c_i;
        for (int i = 1; i < PIPE_REGS; i++) begin
          ctrl_q[i] <= ctrl_q[i-1];
          prod_q[i] <= prod_q[i-1];
          c_q[i]    <= c_q[i-1];
        end
      end
    end

    assign ctrl_o = ctrl_q[PIPE_REGS-1];
    assign prod_o = prod_q[PIPE_REGS-1];
    assign c_o    = c_q[PIPE_REGS-1];
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pipelined multiply-accumulate / add-sub datapath with valid tagging and clock enable
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_WIDTH   = 36,
  parameter int B_WIDTH   = 36,
  parameter int Z_WIDTH   = 108,
  parameter int IN_REGS   = 1,
  parameter int PIPE_REGS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic               is_signed,
  input  logic               addsub,
  input  logic               loadc,
  input  logic               cin,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic [Z_WIDTH-1:0] c,
  output logic               out_valid,
  output logic [Z_WIDTH-1:0] z
);

  localparam int PW = prod_width(A_WIDTH, B_WIDTH);

  if (!widths_ok(A_WIDTH, B_WIDTH, Z_WIDTH, IN_REGS, PIPE_REGS)) begin : g_cfg_error
    $error("dsp_mac_pipe: Z_WIDTH must be >= A_WIDTH+B_WIDTH and IN_REGS/PIPE_REGS within 0..2");
  end

  ctrl_t              in_ctrl;
  ctrl_t              s_ctrl;
  logic [A_WIDTH-1:0] s_a;
  logic [B_WIDTH-1:0] s_b;
  logic [Z_WIDTH-1:0] s_c;

  assign in_ctrl = {is_signed, addsub, loadc, cin, in_valid};

  if (IN_REGS == 0) begin : g_in_comb
    assign s_ctrl = in_ctrl;
    assign s_a    = a;
    assign s_b    = b;
    assign s_c    = c;
  end else begin : g_in_regs
    ctrl_t              ctrl_q [IN_REGS];
    logic [A_WIDTH-1:0] a_q    [IN_REGS];
    logic [B_WIDTH-1:0] b_q    [IN_REGS];
    logic [Z_WIDTH-1:0] c_q    [IN_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < IN_REGS; i++) begin
          ctrl_q[i] <= '0;
          a_q[i]    <= '0;
          b_q[i]    <= '0;
          c_q[i]    <= '0;
        end
      end else if (ce) begin
        ctrl_q[0] <= in_ctrl;
        a_q[0]    <= a;
        b_q[0]    <= b;
        c_q[0]    <= c;
        for (int i = 1; i < IN_REGS; i++) begin
          ctrl_q[i] <= ctrl_q[i-1];
          a_q[i]    <= a_q[i-1];
          b_q[i]    <= b_q[i-1];
          c_q[i]    <= c_q[i-1];
        end
      end
    end

    assign s_ctrl = ctrl_q[IN_REGS-1];
    assign s_a    = a_q[IN_REGS-1];
    assign s_b    = b_q[IN_REGS-1];
    assign s_c    = c_q[IN_REGS-1];
  end

  ctrl_t              m_ctrl;
  logic [PW-1:0]      m_prod;
  logic [Z_WIDTH-1:0] m_c;

  dsp_mult_stage #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .Z_WIDTH  (Z_WIDTH),
    .PIPE_REGS(PIPE_REGS)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .ctrl_i(s_ctrl),
    .a_i   (s_a),
    .b_i   (s_b),
    .c_i   (s_c),
    .ctrl_o(m_ctrl),
    .prod_o(m_prod),
    .c_o   (m_c)
  );

  logic signed [PW-1:0] prod_s;
  logic [Z_WIDTH-1:0]   p_ext;
  logic [Z_WIDTH-1:0]   base;
  logic [Z_WIDTH-1:0]   z_d;
  logic [Z_WIDTH-1:0]   z_q;
  logic                 out_valid_d;
  logic                 out_valid_q;

  assign prod_s = m_prod;

  // The accumulator feeds back within this single stage, so loadc=0 beats never see a stale z
  always_comb begin
    p_ext       = m_ctrl.is_signed ? Z_WIDTH'(prod_s) : Z_WIDTH'(m_prod);
    base        = m_ctrl.loadc ? m_c : z_q;
    z_d         = z_q;
    out_valid_d = m_ctrl.valid;
    if (m_ctrl.valid) begin
      z_d = base + (m_ctrl.addsub ? -p_ext : p_ext) + Z_WIDTH'(m_ctrl.cin);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z         = z_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - randomized self-checking bench for dsp_mac_pipe at pipeline depths L=3, 1 and 5
module tb_dsp_mac_pipe;

  localparam int AW = 36;
  localparam int BW = 36;
  localparam int ZW = 108;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b1;
  logic          in_valid = 1'b0;
  logic          is_signed = 1'b0;
  logic          addsub = 1'b0;
  logic          loadc = 1'b0;
  logic          cin = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic [ZW-1:0] c = '0;
  logic [ND-1:0] ov;
  logic [ZW-1:0] z11, z00, z22;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .IN_REGS(1), .PIPE_REGS(1)) u_dut_11 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed), .addsub(addsub),
    .loadc(loadc), .cin(cin), .a(a), .b(b), .c(c), .out_valid(ov[0]), .z(z11));
  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .IN_REGS(0), .PIPE_REGS(0)) u_dut_00 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed), .addsub(addsub),
    .loadc(loadc), .cin(cin), .a(a), .b(b), .c(c), .out_valid(ov[1]), .z(z00));
  dsp_mac_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .Z_WIDTH(ZW), .IN_REGS(2), .PIPE_REGS(2)) u_dut_22 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .is_signed(is_signed), .addsub(addsub),
    .loadc(loadc), .cin(cin), .a(a), .b(b), .c(c), .out_valid(ov[2]), .z(z22));

  typedef struct {
    logic          s;
    logic          sub;
    logic          ld;
    logic          ci;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [ZW-1:0] c;
    int            acc;
  } beat_t;

  beat_t         beats[$];
  int            nxt    [ND];
  logic [ZW-1:0] exp_z  [ND];
  logic          exp_ov [ND];
  int            n_edge = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [ZW-1:0] seen_z[$];
  int            seen_t[$];
  int            ov_cnt = 0;

  function automatic int lat(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  function automatic logic [ZW-1:0] zget(input int d);
    case (d)
      0:       return z11;
      1:       return z00;
      default: return z22;
    endcase
  endfunction

  function automatic logic [ZW-1:0] mac(input logic [ZW-1:0] zprev, input beat_t bt);
    logic [ZW-1:0] av, bv, p, base;
    av = {{(ZW-AW){bt.s & bt.a[AW-1]}}, bt.a};
    bv = {{(ZW-BW){bt.s & bt.b[BW-1]}}, bt.b};
    p    = av * bv;
    base = bt.ld ? bt.c : zprev;
    if (bt.sub) return base - p + ZW'(bt.ci);
    else        return base + p + ZW'(bt.ci);
  endfunction

  task automatic check(input string tag, input logic [ZW-1:0] got, input logic [ZW-1:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    beats.delete();
    for (int d = 0; d < ND; d++) begin
      nxt[d]    = 0;
      exp_z[d]  = '0;
      exp_ov[d] = 1'b0;
    end
  endtask

  task automatic tick();
    bit    ce_s, v_s;
    beat_t bt;
    ce_s = ce;
    v_s  = in_valid;
    bt   = '{s: is_signed, sub: addsub, ld: loadc, ci: cin, a: a, b: b, c: c, acc: 0};
    @(posedge clk);
    if (ce_s) begin
      n_edge++;
      if (v_s) begin
        bt.acc = n_edge;
        beats.push_back(bt);
      end
      for (int d = 0; d < ND; d++) begin
        exp_ov[d] = 1'b0;
        if (nxt[d] < beats.size()) begin
          if (beats[nxt[d]].acc + lat(d) - 1 == n_edge) begin
            exp_z[d]  = mac(exp_z[d], beats[nxt[d]]);
            exp_ov[d] = 1'b1;
            nxt[d]++;
          end
        end
      end
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("out_valid[L=%0d]", lat(d)), ZW'(ov[d]), ZW'(exp_ov[d]));
      check($sformatf("z[L=%0d]", lat(d)), zget(d), exp_z[d]);
    end
    if (ce_s && ov[0]) begin
      seen_z.push_back(z11);
      seen_t.push_back(n_edge);
      ov_cnt++;
    end
  endtask

  task automatic beat(input bit s, input bit sub, input bit ld, input bit ci,
                      input logic [AW-1:0] av, input logic [BW-1:0] bv, input logic [ZW-1:0] cv);
    is_signed = s; addsub = sub; loadc = ld; cin = ci; a = av; b = bv; c = cv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_z[L=%0d]", lat(d)), zget(d), '0);
      check($sformatf("rst_ov[L=%0d]", lat(d)), ZW'(ov[d]), '0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  function automatic beat_t rand_beat(input bit ld_force);
    beat_t         bt;
    logic [63:0]   r64;
    logic [127:0]  r128;
    bt.s   = 1'($urandom_range(0, 1));
    bt.sub = 1'($urandom_range(0, 1));
    bt.ld  = ld_force | ($urandom_range(0, 3) == 0);
    bt.ci  = 1'($urandom_range(0, 1));
    r64    = {$urandom(), $urandom()};
    bt.a   = r64[AW-1:0];
    r64    = {$urandom(), $urandom()};
    bt.b   = r64[BW-1:0];
    r128   = {$urandom(), $urandom(), $urandom(), $urandom()};
    bt.c   = r128[ZW-1:0];
    bt.acc = 0;
    return bt;
  endfunction

  initial begin
    logic [ZW-1:0] e;
    logic [ZW-1:0] zf;
    int            t0;
    int            ov0;
    beat_t         lst [10];
    beat_t         rb;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("init_z[L=%0d]", lat(d)), zget(d), '0);
      check($sformatf("init_ov[L=%0d]", lat(d)), ZW'(ov[d]), '0);
    end
    rst_n = 1'b1;
    idle(2);

    seen_z.delete(); seen_t.delete();
    beat(0, 0, 1, 1, 36'd3, 36'd5, 108'd10);
    t0 = n_edge;
    idle(6);
    check("t1_count", ZW'(seen_z.size()), ZW'(1));
    if (seen_z.size() > 0) begin
      check("t1_z", seen_z[0], ZW'(26));
      check("t1_latency", ZW'(seen_t[0] - t0 + 1), ZW'(3));
    end

    seen_z.delete(); seen_t.delete();
    beat(1, 0, 1, 0, 36'hF_FFFF_FFFF, 36'd2, '0);
    idle(6);
    e = '1;
    e = e - 1;
    check("t2_count", ZW'(seen_z.size()), ZW'(1));
    if (seen_z.size() > 0) check("t2_z", seen_z[0], e);

    seen_z.delete(); seen_t.delete();
    beat(0, 0, 1, 0, 36'd1, 36'd1, 108'd100);
    repeat (4) beat(0, 1, 0, 0, 36'd5, 36'd5, '0);
    idle(6);
    check("t3_count", ZW'(seen_z.size()), ZW'(5));
    if (seen_z.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t3_z%0d", i), seen_z[i], ZW'(101 - 25 * i));
        check($sformatf("t3_slot%0d", i), ZW'(seen_t[i] - seen_t[0]), ZW'(i));
      end
    end

    seen_z.delete(); seen_t.delete();
    beat(0, 0, 1, 0, 36'd1, 36'd1, '1);
    beat(0, 0, 0, 0, 36'd1, 36'd1, '0);
    idle(6);
    check("t4_count", ZW'(seen_z.size()), ZW'(2));
    if (seen_z.size() == 2) begin
      check("t4_wrap", seen_z[0], '0);
      check("t4_after", seen_z[1], ZW'(1));
    end

    for (int i = 0; i < 10; i++) lst[i] = rand_beat(i == 0);
    zf = '0;
    for (int i = 0; i < 10; i++) zf = mac(zf, lst[i]);
    ov0 = ov_cnt;
    for (int i = 0; i < 10; i++) begin
      is_signed = lst[i].s; addsub = lst[i].sub; loadc = lst[i].ld; cin = lst[i].ci;
      a = lst[i].a; b = lst[i].b; c = lst[i].c;
      in_valid = 1'b1;
      if (i == 4) begin
        ce = 1'b0;
        repeat (3) tick();
        ce = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    idle(6);
    check("t5_final_z", z11, zf);
    check("t5_ov_count", ZW'(ov_cnt - ov0), ZW'(10));

    beat(0, 0, 1, 0, 36'd7, 36'd7, 108'd9);
    beat(0, 0, 0, 0, 36'd7, 36'd7, '0);
    async_reset();
    seen_z.delete(); seen_t.delete();
    idle(6);
    check("t6_no_stale", ZW'(seen_z.size()), '0);
    beat(0, 0, 0, 0, 36'd2, 36'd3, '0);
    idle(6);
    check("t6_count", ZW'(seen_z.size()), ZW'(1));
    if (seen_z.size() > 0) check("t6_from_zero", seen_z[0], ZW'(6));

    for (int cyc = 0; cyc < 600; cyc++) begin
      rb = rand_beat(1'b0);
      is_signed = rb.s; addsub = rb.sub; loadc = rb.ld; cin = rb.ci;
      a = rb.a; b = rb.b; c = rb.c;
      if ($urandom_range(0, 5) == 0) begin
        a = '1;
        b = (rb.b[0]) ? '1 : {1'b1, {(BW-1){1'b0}}};
      end
      in_valid = ($urandom_range(0, 9) < 7);
      ce       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 149) == 0) begin
        tick();
        ce = 1'b1;
        async_reset();
      end else begin
        tick();
      end
    end
    ce = 1'b1;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
